avmm_sram_banks: RTL
====================

AVMM_SRAM_BANKS -- requirements
Module: avmm_sram_banks

Interface
REQ-001 Parameter WORDS_PER_BANK, default 512, 32-bit words per bank; power of two, 16 to 4096.
REQ-002 Parameter READ_LATENCY, default 2, cycles from accepted read to readdatavalid; legal range 1 to 4.
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned for out-of-range addresses.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 slave_address  input  32  byte address; word index = address[2+:log2(WORDS_PER_BANK)], bank = next bit up.
REQ-007 slave_read  input  1  read command.
REQ-008 slave_write  input  1  write command.
REQ-009 slave_writedata  input  32  write data.
REQ-010 slave_waitrequest  output  1  command not accepted this cycle.
REQ-011 slave_readdata  output  32  read data, valid only with slave_readdatavalid.
REQ-012 slave_readdatavalid  output  1  one-cycle pulse per accepted read.
REQ-013 init_done  output  1  high once zero-fill is complete.
REQ-014 err_sticky  output  1  latched protocol or range error; cleared only by reset.

Function
REQ-015 Two banks SHALL be addressed: bank0 at bytes 0 to 4*WORDS_PER_BANK-1, and bank1 at the next 4*WORDS_PER_BANK bytes; any higher address is out-of-range.
REQ-016 The FSM SHALL have two states, INIT and READY; reset enters INIT with the fill counter at 0.
REQ-017 In INIT, one word per cycle SHALL be written to 0 in both banks; after WORDS_PER_BANK cycles the FSM moves to READY and init_done rises.
REQ-018 slave_waitrequest SHALL be high during reset and INIT, and low in READY.
REQ-019 A command is accepted when (slave_read | slave_write) & ~slave_waitrequest.
REQ-020 An accepted write SHALL update the addressed word at that clock edge; writes are not buffered.
REQ-021 Accepted reads SHALL be pipelined, one per cycle, with readdatavalid exactly READ_LATENCY cycles after acceptance, in order.
REQ-022 Reads SHALL return the value of all writes accepted in earlier cycles, including a write in the immediately preceding cycle.
REQ-023 slave_readdata SHALL be 0 whenever slave_readdatavalid is low.
REQ-024 An out-of-range read SHALL return ERR_DATA with normal latency and set err_sticky.
REQ-025 An out-of-range write SHALL be dropped and set err_sticky.
REQ-026 If read and write are both high in READY, the write is performed, the read is dropped (no readdatavalid), and err_sticky is set.
REQ-027 Commands presented while waitrequest is high SHALL have no effect and set no error.
REQ-028 Address bits [1:0] SHALL be ignored.

Reset
REQ-029 Reset SHALL drive readdatavalid=0, readdata=0, init_done=0, err_sticky=0, waitrequest=1, and clear the read pipeline so in-flight reads never complete.
REQ-030 Reset asserted mid-INIT or mid-READY SHALL restart INIT from word 0; memory contents are not relied upon until init_done.

Structure
REQ-031 A shared package avmm_sram_pkg SHALL hold the state enum, ERR_DATA default, and the latency bounds.
REQ-032 One sub-module, sram_bank (single-port synchronous write, registered read, WORDS_PER_BANK x 32), SHALL be instantiated twice.
REQ-033 Read-latency padding beyond the RAM read register SHALL be a valid+data shift register in the top level.

Verification
REQ-034 Reset, then count cycles -> waitrequest high for exactly 512 cycles after reset release, then init_done=1 and a read of 0x004 returns 0.
REQ-035 Write 0x1234_5678 to 0x008, then read 0x008 in the next cycle -> readdatavalid exactly 2 cycles after the read, data 0x1234_5678.
REQ-036 Back-to-back reads of 0x000, 0x800, 0x004 after writing 1, 2, 3 -> three consecutive valid pulses carrying 1, 2, 3.
REQ-037 Read 0x1000 -> data 0xDEAD_BEEF with latency 2 and err_sticky=1; write 0x1000 -> no memory change.
REQ-038 Read and write both high to 0x010 with data 7 -> no valid pulse, err_sticky=1, a later read returns 7.
REQ-039 Assert reset with two reads in flight -> no readdatavalid pulse afterwards, and INIT restarts with waitrequest high.

Source files
------------

// File: rtl/avmm_sram_pkg.sv
// Shared definitions for the two-bank Avalon-MM SRAM slave.
package avmm_sram_pkg;

  // Controller state: INIT zero-fills both banks, READY serves commands.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Data returned for reads that fall outside both banks.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Supported range of cycles from accepted read to readdatavalid.
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

endpackage

// File: rtl/sram_bank.sv
// Single-port synchronous SRAM bank: synchronous write, registered read.
module sram_bank #(
  parameter int WORDS = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  // Write the addressed word and/or register its current contents.
  // NOTE: the array and read register have no reset so they map onto RAM
  // macros; the controller zero-fills the array and gates stale read data.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/avmm_sram_banks.sv
// Avalon-MM slave over two zero-initialised SRAM banks with a pipelined,
// fixed-latency read path and a sticky error flag for bad accesses.
module avmm_sram_banks
  import avmm_sram_pkg::*;
#(
  parameter int          WORDS_PER_BANK = 512,
  parameter int          READ_LATENCY   = 2,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic        init_done,
  output logic        err_sticky
);

  localparam int AW = $clog2(WORDS_PER_BANK);

  state_t          state;
  logic [AW-1:0]   fill_cnt;

  // Byte-lane bits carry no meaning for 32-bit word accesses.
  logic            addr_lsb_unused;
  assign addr_lsb_unused = ^slave_address[1:0];

  // Address decode: word within bank, bank select, anything above is invalid.
  logic [AW-1:0]   word_idx;
  logic            bank_sel;
  logic            out_of_range;
  assign word_idx     = slave_address[2 +: AW];
  assign bank_sel     = slave_address[2 + AW];
  assign out_of_range = |slave_address[31:3 + AW];

  // Command acceptance; a simultaneous read+write keeps only the write.
  logic cmd_accept, wr_accept, rd_accept, cmd_error;
  assign cmd_accept = (slave_read | slave_write) & ~slave_waitrequest;
  assign wr_accept  = cmd_accept & slave_write & ~out_of_range;
  assign rd_accept  = cmd_accept & slave_read & ~slave_write;
  assign cmd_error  = cmd_accept & (out_of_range | (slave_read & slave_write));

  // Zero-fill sequencer: one word per cycle in both banks, then READY.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_INIT;
      fill_cnt          <= '0;
      slave_waitrequest <= 1'b1;
      init_done         <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == AW'(WORDS_PER_BANK - 1)) begin
            state             <= ST_READY;
            slave_waitrequest <= 1'b0;
            init_done         <= 1'b1;
          end
        end
        ST_READY: ;
        default: begin
          state             <= ST_INIT;
          fill_cnt          <= '0;
          slave_waitrequest <= 1'b1;
          init_done         <= 1'b0;
        end
      endcase
    end
  end

  // Bank port muxing: the fill counter owns both ports during INIT.
  logic          init_fill;
  logic [AW-1:0] bank_addr;
  logic [31:0]   bank_wdata;
  logic [31:0]   rdata0, rdata1;
  assign init_fill  = (state == ST_INIT) & rst_n;
  assign bank_addr  = init_fill ? fill_cnt : word_idx;
  assign bank_wdata = init_fill ? 32'h0 : slave_writedata;

  sram_bank #(.WORDS(WORDS_PER_BANK)) u_bank0 (
    .clk   (clk),
    .we    (init_fill | (wr_accept & ~bank_sel)),
    .re    (rd_accept),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (rdata0)
  );

  sram_bank #(.WORDS(WORDS_PER_BANK)) u_bank1 (
    .clk   (clk),
    .we    (init_fill | (wr_accept & bank_sel)),
    .re    (rd_accept),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (rdata1)
  );

  // First read stage, aligned with the RAM read registers.
  logic s0_valid, s0_bank, s0_oor;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_bank  <= 1'b0;
      s0_oor   <= 1'b0;
    end else begin
      s0_valid <= rd_accept;
      s0_bank  <= bank_sel;
      s0_oor   <= out_of_range;
    end
  end

  logic [31:0] s0_data;
  assign s0_data = s0_oor ? ERR_DATA : (s0_bank ? rdata1 : rdata0);

  logic        out_valid;
  logic [31:0] out_data;

  if (READ_LATENCY <= READ_LATENCY_MIN) begin : g_direct
    assign out_valid = s0_valid;
    assign out_data  = s0_data;
  end else begin : g_pad
    logic [READ_LATENCY-1:1] pad_valid;
    logic [31:0]             pad_data [1:READ_LATENCY-1];

    // Valid shift register; cleared by reset so in-flight reads vanish.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pad_valid <= '0;
      end else begin
        pad_valid[1] <= s0_valid;
        for (int i = 2; i < READ_LATENCY; i++) pad_valid[i] <= pad_valid[i-1];
      end
    end

    // Data shift register; contents only matter alongside pad_valid.
    always_ff @(posedge clk) begin
      pad_data[1] <= s0_data;
      for (int i = 2; i < READ_LATENCY; i++) pad_data[i] <= pad_data[i-1];
    end

    assign out_valid = pad_valid[READ_LATENCY-1];
    assign out_data  = pad_data[READ_LATENCY-1];
  end

  assign slave_readdatavalid = out_valid;
  assign slave_readdata      = out_valid ? out_data : 32'h0;

  // Sticky error: range violations and read/write collisions.
  always_ff @(posedge clk) begin
    if (!rst_n)         err_sticky <= 1'b0;
    else if (cmd_error) err_sticky <= 1'b1;
  end

endmodule
